// File: rtl/mic1_memsys.sv
// MIC-1 memory subsystem: one single-port RAM shared by the 32-bit word port and the
// 8-bit fetch port, with a memory-mapped output register, range error flag and zero-fill.
module mic1_memsys #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] OUT_ADDR       = 32'h3FFF_FFFF,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter              INIT_FILE      = ""
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        busy,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic [7:0]  fetch_data,
  output logic        fetch_valid,
  output logic [31:0] out,
  output logic        err
);
  // state | meaning
  // CLEAR | write 0 to RAM word clr_idx each cycle; all grants held low
  // RUN   | arbitrate word and fetch ports, one RAM access per cycle
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [31:0] DEPTH       = 32'd1 << ADDR_WIDTH;
  localparam state_t      RESET_STATE = state_t'(CLEAR_ON_RESET ? S_CLEAR : S_RUN);

  state_t                state, state_nxt;
  logic                  run;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [31:0]           ram [0:DEPTH-1];

  logic                  word_req, word_rd, out_hit, word_in_range, fetch_in_range;
  logic [ADDR_WIDTH-1:0] word_idx, fetch_idx, rd_idx, ram_waddr;
  logic [31:0]           rd_word, ram_wdata;
  logic [7:0]            fetch_byte;
  logic                  ram_we;

  assign word_req       = mem_rd | mem_wr;
  assign word_rd        = mem_rd & ~mem_wr;
  assign out_hit        = (mem_addr == OUT_ADDR);
  assign word_in_range  = (mem_addr < DEPTH);
  assign fetch_in_range = ({2'b00, fetch_addr[31:2]} < DEPTH);
  assign word_idx       = mem_addr[ADDR_WIDTH-1:0];
  assign fetch_idx      = fetch_addr[ADDR_WIDTH+1:2];

  // Word port has fixed priority; a starved fetch simply keeps waiting.
  assign mem_gnt   = word_req & run;
  assign fetch_gnt = fetch_req & ~word_req & run;

  assign rd_idx  = mem_gnt ? word_idx : fetch_idx;
  assign rd_word = ram[rd_idx];

  always_comb begin
    case (fetch_addr[1:0])
      2'd0:    fetch_byte = rd_word[31:24];
      2'd1:    fetch_byte = rd_word[23:16];
      2'd2:    fetch_byte = rd_word[15:8];
      default: fetch_byte = rd_word[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RESET_STATE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_idx == {ADDR_WIDTH{1'b1}}) state_nxt = S_RUN;
  end

  // Grants are also gated by resetn so nothing is accepted while reset is held.
  always_comb begin
    busy = (state == S_CLEAR);
    run  = (state == S_RUN) & resetn;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   clr_idx <= '0;
    else if (busy) clr_idx <= clr_idx + 1'b1;
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = word_idx;
    ram_wdata = mem_wdata;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end else if (mem_gnt && mem_wr && !out_hit && word_in_range) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out         <= '0;
      err         <= 1'b0;
      mem_rdata   <= '0;
      mem_rvalid  <= 1'b0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      mem_rvalid  <= mem_gnt & word_rd;
      fetch_valid <= fetch_gnt;
      if (mem_gnt && mem_wr && out_hit) out <= mem_wdata;
      if (mem_gnt && word_rd)
        mem_rdata <= out_hit ? out : (word_in_range ? rd_word : 32'h0);
      if (fetch_gnt) fetch_data <= fetch_in_range ? fetch_byte : 8'h00;
      if ((mem_gnt && ((!out_hit && !word_in_range) || (mem_rd && mem_wr))) ||
          (fetch_gnt && !fetch_in_range))
        err <= 1'b1;
    end
  end
endmodule
